// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Optional scoreboard macro: REGFILE_WB_SCOREBOARD_EN.
package regfile_wb_arbiter_pkg;
  localparam int REG_NUM          = 32;
  localparam int REG_AW           = 5;
  localparam int BANK_BIT         = 0;
  localparam int WB_DEFAULT_WIDTH = 32;

  typedef struct packed {
    logic [REG_AW-1:0]           addr;
    logic [WB_DEFAULT_WIDTH-1:0] data;
  } wb_req_t;

  function automatic logic addr_bank(input logic [REG_AW-1:0] addr);
    return addr[BANK_BIT];
  endfunction
endpackage

// File: rtl/wb_bank_fifo.sv
// Per-bank write queue: up to two pushes and one pop per cycle, head always presented.
// Pending-register decode is built only when REGFILE_WB_SCOREBOARD_EN is defined.
module wb_bank_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int   WIDTH  = 32,
  parameter int   QDEPTH = 4,
  parameter logic BANK   = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push0_i,
  input  logic [REG_AW-2:0]         hi0_i,
  input  logic [WIDTH-1:0]          data0_i,
  input  logic                      push1_i,
  input  logic [REG_AW-2:0]         hi1_i,
  input  logic [WIDTH-1:0]          data1_i,
  output logic                      we_o,
  output logic [REG_AW-1:0]         wa_o,
  output logic [WIDTH-1:0]          wd_o,
  output logic [$clog2(QDEPTH):0]   count_o,
  output logic [REG_NUM-1:0]        pending_o
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  // Only the upper address bits are stored; the bank bit is implied by BANK.
  logic [REG_AW-2:0] hi_q  [QDEPTH];
  logic [WIDTH-1:0]  dat_q [QDEPTH];
  logic [PW-1:0]     rptr_q, rptr_d, wptr_q, wptr_d, wptr1;
  logic [CW-1:0]     count_q, count_d;
  logic              ne_q;
  logic              pop;

  always_comb begin
    pop     = ne_q;
    wptr1   = wptr_q + PW'(push0_i);
    wptr_d  = wptr_q + PW'(push0_i) + PW'(push1_i);
    rptr_d  = rptr_q + PW'(pop);
    count_d = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        hi_q[i]  <= '0;
        dat_q[i] <= '0;
      end
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      ne_q    <= 1'b0;
    end else begin
      if (push0_i) begin
        hi_q[wptr_q]  <= hi0_i;
        dat_q[wptr_q] <= data0_i;
      end
      if (push1_i) begin
        hi_q[wptr1]  <= hi1_i;
        dat_q[wptr1] <= data1_i;
      end
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      ne_q    <= (count_d != '0);
    end
  end

  assign we_o    = ne_q;
  assign wa_o    = {hi_q[rptr_q], BANK};
  assign wd_o    = dat_q[rptr_q];
  assign count_o = count_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
  // Entry i is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PW-1:0] off;
    off       = '0;
    pending_o = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      off = PW'(i) - rptr_q;
      if ({1'b0, off} < count_q) pending_o[{hi_q[i], BANK}] = 1'b1;
    end
  end
`else
  assign pending_o = '0;
`endif
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: sorts two commit writes per cycle into even/odd bank queues.
// Define REGFILE_WB_SCOREBOARD_EN to build the pending-write scoreboard.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int WIDTH  = WB_DEFAULT_WIDTH,
  parameter int QDEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         wb_valid_i,
  input  logic [REG_AW-1:0]  wb_addr0_i,
  input  logic [WIDTH-1:0]   wb_data0_i,
  input  logic [REG_AW-1:0]  wb_addr1_i,
  input  logic [WIDTH-1:0]   wb_data1_i,
  output logic               wb_ready_o,
  output logic [REG_AW-1:0]  wa0_o,
  output logic [REG_AW-1:0]  wa1_o,
  output logic               we0_o,
  output logic               we1_o,
  output logic [WIDTH-1:0]   wd0_o,
  output logic [WIDTH-1:0]   wd1_o,
  output logic [REG_NUM-1:0] pending_o,
  output logic               idle_o
);
  localparam int CW = $clog2(QDEPTH) + 1;

  logic [CW-1:0]      cnt0, cnt1;
  logic [REG_NUM-1:0] pend0, pend1;
  logic               acc0, acc1;
  logic               push00, push01, push10, push11;

  // Handshake: port p transfers on a rising edge where wb_valid_i[p] && wb_ready_o.
  // wb_ready_o depends only on registered counts, leaving room for a 2-push per bank.
  assign wb_ready_o = (cnt0 <= CW'(QDEPTH - 2)) && (cnt1 <= CW'(QDEPTH - 2));
  assign idle_o     = (cnt0 == '0) && (cnt1 == '0);

  always_comb begin
    acc0   = wb_valid_i[0] && wb_ready_o && (wb_addr0_i != '0);
    acc1   = wb_valid_i[1] && wb_ready_o && (wb_addr1_i != '0);
    push00 = acc0 && !addr_bank(wb_addr0_i);
    push01 = acc1 && !addr_bank(wb_addr1_i);
    push10 = acc0 &&  addr_bank(wb_addr0_i);
    push11 = acc1 &&  addr_bank(wb_addr1_i);
  end

  wb_bank_fifo #(.WIDTH(WIDTH), .QDEPTH(QDEPTH), .BANK(1'b0)) u_bank0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push0_i   (push00),
    .hi0_i     (wb_addr0_i[REG_AW-1:1]),
    .data0_i   (wb_data0_i),
    .push1_i   (push01),
    .hi1_i     (wb_addr1_i[REG_AW-1:1]),
    .data1_i   (wb_data1_i),
    .we_o      (we0_o),
    .wa_o      (wa0_o),
    .wd_o      (wd0_o),
    .count_o   (cnt0),
    .pending_o (pend0)
  );

  wb_bank_fifo #(.WIDTH(WIDTH), .QDEPTH(QDEPTH), .BANK(1'b1)) u_bank1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push0_i   (push10),
    .hi0_i     (wb_addr0_i[REG_AW-1:1]),
    .data0_i   (wb_data0_i),
    .push1_i   (push11),
    .hi1_i     (wb_addr1_i[REG_AW-1:1]),
    .data1_i   (wb_data1_i),
    .we_o      (we1_o),
    .wa_o      (wa1_o),
    .wd_o      (wd1_o),
    .count_o   (cnt1),
    .pending_o (pend1)
  );

  assign pending_o = pend0 | pend1;
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter sitting directly upstream of the 2-bank, 2-write-port integer register file. Accepts up to two write-back requests per cycle from the commit stage, sorts them by bank (address bit 0), buffers them per bank and presents at most one even and one odd write per cycle, so the register file's bank-conflict condition never arises. Also exports a pending-write scoreboard that the issue stage uses to stall readers of registers with writes still in flight.

## Interface
Parameters:
- WIDTH, 32, data width of one register
- QDEPTH, 4, entries per bank queue (power of two, ≥ 2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- wb_valid_i  in  2  request valid per port; port 0 is older in program order
- wb_addr0_i / wb_addr1_i  in  5  destination register
- wb_data0_i / wb_data1_i  in  WIDTH  write data
- wb_ready_o  out  1  both ports accepted this cycle when high (shared)
- wa0_o  out  5  even-bank write address to register file (bit 0 always 0)
- wa1_o  out  5  odd-bank write address (bit 0 always 1)
- we0_o / we1_o  out  1  write enables
- wd0_o / wd1_o  out  WIDTH  write data
- pending_o  out  32  bit r set while any queued write targets r
- idle_o  out  1  both queues empty

## Operation
- Acceptance: port p is taken on a clock edge when wb_valid_i[p] && wb_ready_o. wb_ready_o = 1 iff each bank queue holds ≤ QDEPTH−2 entries (registered counts; no combinational path from wb_valid_i).
- Address 0 writes are accepted and discarded; never enqueued, never set pending_o.
- Steering: addr[0]=0 → bank-0 queue, addr[0]=1 → bank-1 queue. If both accepted requests hit the same bank, port 0 is enqueued ahead of port 1 in the same edge (2-push).
- Ordering: writes to the same register retire in acceptance order; identical addresses on both ports in one cycle → both retire, port-1 data is the final value.
- Issue: each queue pops at most one entry per cycle. we0_o = bank-0 queue non-empty, {wa0_o, wd0_o} = its head; same for bank 1. Outputs are driven from queue storage (no logic after flops besides head select). Head pops on every edge where it is presented; the register file has no backpressure.
- wa0_o[0] is forced 0 and wa1_o[0] forced 1, so the register file's port steering always maps port 0 → even bank, port 1 → odd bank.
- pending_o: OR over both queues of one-hot decode of every valid entry's address.
- Reset (rst_n low at edge): both queues flushed, counts 0. Outputs after reset: we0_o=we1_o=0, wa0_o=5'd0, wa1_o=5'd1, wd0_o=wd1_o=0, pending_o=0, idle_o=1, wb_ready_o=1. A reset mid-stream drops all queued writes silently.

## Timing
- Request accepted at edge E0 → we*_o high during cycle after E0 → register written at E1. Minimum latency 1 cycle, empty queue.
- Each additional older entry in the same bank adds 1 cycle.
- pending_o[r] sets in the cycle after acceptance and clears in the cycle after the last write to r is presented (i.e. after the register file has written it).
- Throughput: 2 writes/cycle sustained when alternate banks; 1/cycle for a single-bank stream, with wb_ready_o deasserting once that queue exceeds QDEPTH−2.
- Queue pointers wrap modulo QDEPTH; count width clog2(QDEPTH)+1.

## Configuration
- REGFILE_WB_SCOREBOARD_EN defined: pending_o computed as above.
- Not defined: pending_o tied to 32'd0, decode logic absent; issue stage must instead stall on !idle_o. All other behaviour unchanged.

## Structure
- Shared package: typedef wb_req_t {addr[4:0], data[WIDTH-1:0]}, constant REG_NUM=32, bank-select bit index.
- One sub-module: wb_bank_fifo — QDEPTH-entry, 2-push/1-pop FIFO with count output, instantiated once per bank.

## Test plan
- Reset then wb_valid_i=2'b11, addr0=2/data 0xA, addr1=3/data 0xB → next cycle we0=we1=1, wa0=2, wa1=3, pending_o bits 2,3 set for one cycle, then idle_o=1.
- Same bank: addr0=4/0x11, addr1=6/0x22 → cycle+1 wa0=4, cycle+2 wa0=6, we1 stays 0.
- Same address: both ports addr=5, data 0x1 then 0x2 → two successive odd writes, last wd1_o=0x2.
- Stream to even bank every cycle with both ports, QDEPTH=4 → wb_ready_o drops when bank-0 count exceeds 2; no entry lost or reordered.
- Addr 0 on port 0 with addr 7 on port 1 → only wa1=7 written, pending_o[0] never set.
- Assert rst_n low with 3 entries queued → next cycle we*=0, pending_o=0, idle_o=1, wb_ready_o=1.
